// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package riscv_mem_pkg;

   localparam int ADDR_W_DEF      = 32;
   localparam int DATA_W_DEF      = 32;
   localparam int MAX_DSTREAK_DEF = 4;
   localparam int TIMEOUT_DEF     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Serialising arbiter sharing one single-port memory between the fetch (I) and
// load/store (D) ports; D has priority, bounded by an anti-starvation streak.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic [1:0]          dbg_state
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
   localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

   // Handshake: a port request is accepted in the cycle its x_gnt is high; an
   // unaccepted request must be held. mem_req is held until mem_gnt, then the
   // arbiter waits for exactly one mem_rvalid and returns a one-cycle x_rvalid.
   state_t             state;
   owner_t             owner;
   logic [SW-1:0]      streak;
   logic [7:0]         timer;
   logic               lat_we;
   logic [BE_W-1:0]    lat_be;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;

   logic               rsp_done;
   logic               rsp_err;
   logic [DATA_W-1:0]  rsp_data;

   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (state == IDLE) begin
         if (d_req && !(i_req && streak == STREAK_MAX)) d_gnt = 1'b1;
         else if (i_req)                                i_gnt = 1'b1;
      end
   end

   always_comb begin
      rsp_done = (state == WAIT) && (mem_rvalid || timer == TMO_LAST);
      rsp_err  = !mem_rvalid;
      rsp_data = (mem_rvalid && !lat_we) ? mem_rdata : '0;
   end

   assign mem_req   = (state == ISSUE);
   assign mem_we    = lat_we;
   assign mem_be    = lat_be;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         streak    <= '0;
         timer     <= '0;
         lat_we    <= 1'b0;
         lat_be    <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         i_rvalid  <= 1'b0;
         i_rdata   <= '0;
         i_err     <= 1'b0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
         d_err     <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         i_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (d_gnt) begin
                  owner     <= OWN_D;
                  lat_we    <= d_we;
                  lat_be    <= d_be;
                  lat_addr  <= d_addr;
                  lat_wdata <= d_wdata;
                  state     <= ISSUE;
                  // Only D wins that keep a pending fetch waiting count toward the streak.
                  if (!i_req)                    streak <= '0;
                  else if (streak != STREAK_MAX) streak <= streak + SW'(1);
               end else if (i_gnt) begin
                  owner     <= OWN_I;
                  lat_we    <= 1'b0;
                  lat_be    <= '1;
                  lat_addr  <= i_addr;
                  lat_wdata <= '0;
                  streak    <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  state <= WAIT;
                  timer <= '0;
               end
            end
            WAIT: begin
               timer <= timer + 8'd1;
               if (rsp_done) begin
                  state <= IDLE;
                  if (owner == OWN_I) begin
                     i_rvalid <= 1'b1;
                     i_rdata  <= rsp_data;
                     i_err    <= rsp_err;
                  end else begin
                     d_rvalid <= 1'b1;
                     d_rdata  <= rsp_data;
                     d_err    <= rsp_err;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter with a behavioural memory that can
// stall mem_gnt and delay or withhold mem_rvalid.
module tb_riscv_mem_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          gcyc;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   exp_t        i_q[$];
   exp_t        d_q[$];
   logic [68:0] bus_q[$];
   logic [31:0] i_last = '0;
   logic [31:0] d_last = '0;
   logic [31:0] mem [logic [31:0]];

   int gd = 0;
   int rd = 1;
   int rsp_cnt = -1;
   int wait_cnt = 0;
   bit hold_v = 0;
   logic [68:0] held;
   logic [31:0] rsp_data;

   riscv_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic void mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] w;
      w = mem_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      mem[a] = w;
   endfunction

   // Expectations are built at the moment a grant is observed.
   function automatic void push_exp(input bit is_d, input logic we, input logic [3:0] be,
                                    input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      e.err  = (rd > TIMEOUT);
      e.data = (e.err || we) ? 32'h0 : mem_rd(a);
      e.lat  = e.err ? 2 + gd + TIMEOUT : 2 + gd + rd;
      e.gcyc = cyc;
      if (is_d) begin
         d_q.push_back(e);
         bus_q.push_back({we, be, a, wd});
      end else begin
         i_q.push_back(e);
         bus_q.push_back({1'b0, 4'hF, a, 32'h0});
      end
   endfunction

   // memory model
   initial begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (!reset_n) begin
            rsp_cnt = -1;
            hold_v = 0;
            wait_cnt = 0;
         end else begin
            if (rsp_cnt > 0) begin
               rsp_cnt--;
               if (rsp_cnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata = rsp_data;
                  rsp_cnt = -1;
               end
            end
            if (mem_req) begin
               if (!hold_v) begin
                  hold_v = 1;
                  held = {mem_we, mem_be, mem_addr, mem_wdata};
                  if (bus_q.size() == 0) check("bus_unexpected", mem_req, 0);
                  else check("bus_fields", {mem_we, mem_be, mem_addr, mem_wdata}, bus_q.pop_front());
               end else begin
                  check("bus_stable", {mem_we, mem_be, mem_addr, mem_wdata}, held);
               end
               if (wait_cnt < gd) wait_cnt++;
               else begin
                  mem_gnt = 1'b1;
                  wait_cnt = 0;
                  hold_v = 0;
                  if (mem_we) begin
                     mem_wr(mem_addr, mem_be, mem_wdata);
                     rsp_data = 32'hFFFF_FFFF;
                  end else begin
                     rsp_data = mem_rd(mem_addr);
                  end
                  rsp_cnt = rd;
               end
            end
         end
      end
   end

   // scoreboard: response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (i_rvalid) begin
               if (i_q.size() == 0) check("i_rvalid_spurious", i_rvalid, 0);
               else begin
                  e = i_q.pop_front();
                  check("i_rdata", i_rdata, e.data);
                  check("i_err", i_err, e.err);
                  check("i_latency", cyc - e.gcyc, e.lat);
                  check("d_rdata_hold", d_rdata, d_last);
                  i_last = e.data;
               end
            end
            if (d_rvalid) begin
               if (d_q.size() == 0) check("d_rvalid_spurious", d_rvalid, 0);
               else begin
                  e = d_q.pop_front();
                  check("d_rdata", d_rdata, e.data);
                  check("d_err", d_err, e.err);
                  check("d_latency", cyc - e.gcyc, e.lat);
                  check("i_rdata_hold", i_rdata, i_last);
                  d_last = e.data;
               end
            end
         end
      end
   end

   // driver tasks
   task automatic issue_i(input logic [31:0] a);
      bit got = 0;
      @(posedge clk);
      #1;
      i_req = 1'b1;
      i_addr = a;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (i_gnt) begin
            check("i_gnt_excl", d_gnt, 0);
            push_exp(0, 1'b0, 4'hF, a, 32'h0);
            got = 1;
         end
      end
      if (!got) check("i_gnt_timeout", got, 1);
      @(posedge clk);
      #1;
      i_req = 1'b0;
   endtask

   task automatic issue_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd);
      bit got = 0;
      @(posedge clk);
      #1;
      d_req = 1'b1;
      d_we = we;
      d_be = be;
      d_addr = a;
      d_wdata = wd;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (d_gnt) begin
            check("d_gnt_excl", i_gnt, 0);
            push_exp(1, we, be, a, wd);
            got = 1;
         end
      end
      if (!got) check("d_gnt_timeout", got, 1);
      @(posedge clk);
      #1;
      d_req = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (i_q.size() == 0 && d_q.size() == 0 && !busy) done = 1;
      end
      if (!done) check("drain_timeout", done, 1);
   endtask

   initial begin
      int k;
      int prev_g;
      logic [7:0] got_c;
      logic [7:0] exp_c;
      logic [31:0] a;
      bit seen;

      reset_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem[32'h100] = 32'h0050_0093;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_fields", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
      check("rst_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
      check("rst_rdata", {i_rdata, d_rdata}, 0);
      check("rst_gnt", {i_gnt, d_gnt}, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // single fetch, then store with partial byte enables and a read-back
      issue_i(32'h100);
      wait_drain();
      issue_d(1'b1, 4'h3, 32'h200, 32'hDEAD_BEEF);
      wait_drain();
      issue_d(1'b0, 4'hF, 32'h200, 32'h0);
      wait_drain();

      // contention: both ports request continuously
      @(posedge clk);
      #1;
      i_req = 1'b1; i_addr = 32'h180;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; d_wdata = '0;
      k = 0;
      prev_g = 0;
      for (int n = 0; n < 200 && k < 10; n++) begin
         @(negedge clk);
         if (i_gnt || d_gnt) begin
            check("gnt_onehot", i_gnt & d_gnt, 0);
            got_c = d_gnt ? 8'h44 : 8'h49;
            exp_c = (k % 5 == 4) ? 8'h49 : 8'h44;
            check("grant_order", got_c, exp_c);
            if (k > 0) check("gnt_spacing", cyc - prev_g, 3);
            prev_g = cyc;
            if (d_gnt) push_exp(1, 1'b0, 4'hF, 32'h300, 32'h0);
            else       push_exp(0, 1'b0, 4'hF, 32'h180, 32'h0);
            k++;
         end
      end
      if (k < 10) check("contention_grants", k, 10);
      @(posedge clk);
      #1;
      i_req = 1'b0;
      d_req = 1'b0;
      wait_drain();

      // mem_gnt withheld for 5 cycles
      gd = 5;
      issue_d(1'b1, 4'hC, 32'h240, 32'h1234_5678);
      wait_drain();
      issue_i(32'h104);
      wait_drain();
      gd = 0;

      // timeouts: response never in time, then the boundary either side
      rd = 20;
      issue_d(1'b0, 4'hF, 32'h280, 32'h0);
      wait_drain();
      repeat (8) @(negedge clk);
      rd = TIMEOUT;
      issue_i(32'h284);
      wait_drain();
      rd = TIMEOUT + 1;
      issue_d(1'b0, 4'hF, 32'h288, 32'h0);
      wait_drain();
      repeat (4) @(negedge clk);
      rd = 1;

      // random traffic
      for (int n = 0; n < 12; n++) begin
         gd = $urandom_range(0, 2);
         rd = $urandom_range(1, 3);
         a = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 1) == 1) issue_i(a);
         else issue_d(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a, $urandom);
         wait_drain();
      end
      gd = 0;
      rd = 1;

      // reset during WAIT
      rd = 1000;
      issue_d(1'b0, 4'hF, 32'h2C0, 32'h0);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (dbg_state == 2'd2) seen = 1;
         else @(negedge clk);
      end
      check("reached_wait", seen, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_mem_req", mem_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_state", dbg_state, 0);
      check("midrst_outputs", {i_rvalid, d_rvalid, i_err, d_err, i_rdata, d_rdata}, 0);
      i_q.delete();
      d_q.delete();
      bus_q.delete();
      i_last = '0;
      d_last = '0;
      rd = 1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (25) @(negedge clk);
      issue_i(32'h100);
      wait_drain();
      issue_d(1'b0, 4'hF, 32'h200, 32'h0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #400000;
      check("global_timeout", 1, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
